lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit directly downstream of the ALU in the RV32 datapath. Takes the ALU's effective address (`ALUresult`), store data and funct3 of a load/store, runs a request/acknowledge transaction with a variable-latency data memory, and returns the aligned, sign- or zero-extended load value. It holds a stall (`Busy`) toward the core until the access completes. Misaligned accesses and bus timeouts are reported on `Fault`.

## Interface
- `TIMEOUT`, default 16: WAIT cycles without `mem_ack` before a bus fault (only with `LSU_TIMEOUT_EN`).
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `Start` in 1: access request, sampled only in IDLE.
- `MemWrite` in 1: 1 = store, 0 = load.
- `Funct3` in 3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- `ALUresult` in 32: effective byte address from the ALU.
- `WriteData` in 32: store data (rs2).
- `Busy` out 1: core stall; high in WAIT.
- `Done` out 1: one-cycle completion pulse.
- `ReadData` out 32: extended load result.
- `Fault` out 2: 00 ok, 01 misaligned/illegal funct3, 10 bus timeout; valid with `Done`.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word address `{ALUresult[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables.
- `mem_rdata` in 32: memory read word, valid with `mem_ack`.
- `mem_ack` in 1: memory completion strobe.

## Operation
- FSM states IDLE, WAIT, DONE; all outputs registered.
- IDLE + `Start`: latch `MemWrite`, `Funct3`, offset `ALUresult[1:0]`; decode legality.
  - Legal: next WAIT; drive `mem_req`=1, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`; `Busy`=1.
  - Misaligned (half with offset[0]=1, word with offset≠0) or illegal funct3 (011, 11x; 1xx on store): next DONE, `Fault`=01, no memory request.
- Byte enables: byte `4'b0001<<off`; half `4'b0011<<off`; word `4'b1111`.
- Store data: SB `{4{WriteData[7:0]}}`, SH `{2{WriteData[15:0]}}`, SW `WriteData`.
- WAIT + `mem_ack`: drop `mem_req`; on load, `ReadData` = lane `mem_rdata[8*off +: 8/16/32]`, sign-extended (LB/LH) or zero-extended (LBU/LHU); next DONE, `Fault`=00.
- DONE: `Done`=1 one cycle, `Busy`=0, next IDLE.
- `ReadData` updated only on successful load; holds across stores and faults.
- `Start` in WAIT/DONE ignored; core keeps operands stable until `Done`.
- `mem_ack` outside WAIT ignored (late ack after reset/timeout dropped).
- `reset`: state IDLE, every output 0 (`ReadData`, `Fault`, `mem_*`, `Busy`, `Done`), timeout counter 0. Reset during WAIT drops `mem_req` on that edge.

## Timing
- `Start` sampled at edge 0 → `mem_req`/`Busy` high after edge 0.
- Ack sampled at edge k (k≥1) → `Done`, `ReadData`, `Fault` valid after edge k for one cycle; `mem_req`/`Busy` low after edge k.
- Zero-wait memory (ack in first WAIT cycle): `Done` 2 cycles after `Start`.
- Misaligned: `Done`+`Fault`=01 one cycle after `Start`; `mem_req` never asserted.
- Earliest new `Start` accepted the cycle after `Done`.

## Configuration
- `LSU_TIMEOUT_EN` defined: 5-bit-min counter increments each WAIT cycle without ack; at `TIMEOUT` cycles drop `mem_req`, go DONE with `Fault`=10; ack in the same cycle as expiry wins (normal completion).
- Undefined: no counter; WAIT holds indefinitely; `Fault` never 10.

## Test plan
- LW addr 0x00000104, ack after 3 wait cycles, rdata 0xDEADBEEF → `mem_addr`=0x104, `mem_be`=1111, `Busy` high 4 cycles, `ReadData`=0xDEADBEEF, `Fault`=00.
- LB addr 0x203 rdata 0x80FF7F01 → `mem_be`=1000, `ReadData`=0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x202 → 0x000080FF.
- SH addr 0x102, `WriteData`=0x12345678 → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0x56785678, `ReadData` unchanged.
- LW addr 0x101 → `Done` next cycle, `Fault`=01, `mem_req` never high; Funct3=011 → same.
- With `LSU_TIMEOUT_EN`, `TIMEOUT`=16, no ack → `Done` with `Fault`=10 after 16 WAIT cycles; later stray `mem_ack` in IDLE → no effect.
- `reset` asserted in WAIT → all outputs 0 after that edge, next `Start` serviced normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//
// Load/store unit that sits after the ALU in the RV32 datapath. It takes an
// effective byte address, store data and funct3 for a load or store. It runs
// one request/acknowledge transaction with a variable-latency data memory.
// For loads it returns the selected byte, half or word, sign- or
// zero-extended. The core is stalled through Busy until the access completes.
//
// Optional feature (macro LSU_TIMEOUT_EN):
//   When defined, the module has a TIMEOUT parameter (default 16). An access
//   that waits TIMEOUT cycles without mem_ack is abandoned and reported as a
//   bus fault. When undefined, the WAIT state holds until mem_ack arrives.
//
// Ports:
//   clk, reset      single clock; synchronous active-high reset
//   Start           access request, only looked at while idle
//   MemWrite        1 = store, 0 = load
//   Funct3          RV32 load/store funct3
//   ALUresult       effective byte address
//   WriteData       store data (rs2)
//   Busy            stall toward the core while the memory access is pending
//   Done            one-cycle completion pulse
//   ReadData        extended load result (updated only by successful loads)
//   Fault           00 ok, 01 misaligned/illegal funct3, 10 bus timeout
//   mem_req         memory request, held until mem_ack
//   mem_we          memory write enable
//   mem_addr        word-aligned memory address
//   mem_wdata       store data replicated across the byte lanes
//   mem_be          byte enables
//   mem_rdata       read word from memory, valid with mem_ack
//   mem_ack         memory completion strobe
// ---------------------------------------------------------------------------
module lsu_mem_stage
`ifdef LSU_TIMEOUT_EN
#(
    parameter int TIMEOUT = 16
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUresult,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] ReadData,
    output logic [1:0]  Fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_OK      = 2'b00;
    localparam logic [1:0] FAULT_ALIGN   = 2'b01;
`ifdef LSU_TIMEOUT_EN
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // At least 5 bits, wider if TIMEOUT needs it.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
`endif

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] read_data_q, read_data_d;
    logic [1:0]  fault_q, fault_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        is_write_q, is_write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Request decode for the incoming access (used only while idle).
    logic [1:0]  req_off;
    logic        req_funct_ok;
    logic        req_aligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    always_comb begin
        req_off      = ALUresult[1:0];
        req_funct_ok = 1'b0;
        req_aligned  = 1'b0;
        req_be       = 4'b0000;
        req_wdata    = WriteData;

        // Stores only know SB/SH/SW; loads add the unsigned LBU/LHU forms.
        if (MemWrite) begin
            req_funct_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
        end else begin
            req_funct_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                           (Funct3 == 3'b100) || (Funct3 == 3'b101);
        end

        case (Funct3[1:0])
            2'b00: begin
                req_aligned = 1'b1;
                req_be      = 4'b0001 << req_off;
                req_wdata   = {4{WriteData[7:0]}};
            end
            2'b01: begin
                req_aligned = ~req_off[0];
                req_be      = 4'b0011 << req_off;
                req_wdata   = {2{WriteData[15:0]}};
            end
            2'b10: begin
                req_aligned = (req_off == 2'b00);
                req_be      = 4'b1111;
                req_wdata   = WriteData;
            end
            default: begin
                req_aligned = 1'b0;
                req_be      = 4'b0000;
                req_wdata   = WriteData;
            end
        endcase
    end

    // Load data extraction from the returned word using the latched offset.
    logic [31:0] lane;
    logic [31:0] load_value;

    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_value = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_value = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_value = {24'd0, lane[7:0]};
            3'b101:  load_value = {16'd0, lane[15:0]};
            default: load_value = lane;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        read_data_d = read_data_q;
        fault_d     = fault_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        is_write_d  = is_write_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (Start) begin
                    is_write_d = MemWrite;
                    funct3_d   = Funct3;
                    off_d      = req_off;
                    if (req_funct_ok && req_aligned) begin
                        state_d     = S_WAIT;
                        busy_d      = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWrite;
                        mem_addr_d  = {ALUresult[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata;
`ifdef LSU_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        // Rejected before touching the bus.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = FAULT_ALIGN;
                    end
                end
            end

            S_WAIT: begin
                if (mem_ack) begin
                    // An ack arriving on the expiry cycle still completes normally.
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    fault_d   = FAULT_OK;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!is_write_q) begin
                        read_data_d = load_value;
                    end
`ifdef LSU_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    fault_d   = FAULT_TIMEOUT;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_data_q <= '0;
            fault_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            is_write_q  <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            read_data_q <= read_data_d;
            fault_q     <= fault_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            is_write_q  <= is_write_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign ReadData  = read_data_q;
    assign Fault     = fault_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_stage
//
// Directed self-checking bench for lsu_mem_stage. Inputs are driven and
// outputs sampled 1 ns after each rising clock edge. The bench plays the
// memory role by driving mem_ack and mem_rdata itself. The timeout scenario
// follows the LSU_TIMEOUT_EN macro, so it matches whichever build is compiled.
// ---------------------------------------------------------------------------
module tb_lsu_mem_stage;

    logic        clk;
    logic        reset;
    logic        Start;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUresult;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic [31:0] ReadData;
    logic [1:0]  Fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int assertCount = 0;
    int failCount   = 0;

    lsu_mem_stage dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUresult (ALUresult),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .ReadData  (ReadData),
        .Fault     (Fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        Start     = start;
        MemWrite  = we;
        Funct3    = f3;
        ALUresult = addr;
        WriteData = wdata;
    endtask

    // Run one legal access, with the ack arriving after waitCycles empty WAIT cycles.
    task automatic doAccess(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int waitCycles, input logic [31:0] rdata,
                            input logic [3:0] expBe, input logic [31:0] expWdata,
                            input logic [31:0] expRead);
        int busyCycles;
        busyCycles = 0;
        applyStimulus(1'b1, we, f3, addr, wdata);
        tick();
        Start = 1'b0;
        checkOutput({tag, " req"},   32'(mem_req), 32'd1);
        checkOutput({tag, " we"},    32'(mem_we), 32'(we));
        checkOutput({tag, " addr"},  mem_addr, {addr[31:2], 2'b00});
        checkOutput({tag, " be"},    32'(mem_be), 32'(expBe));
        if (we) checkOutput({tag, " wdata"}, mem_wdata, expWdata);
        if (Busy) busyCycles++;
        for (int i = 0; i < waitCycles; i++) begin
            tick();
            if (Busy) busyCycles++;
            checkOutput({tag, " req held"}, 32'(mem_req), 32'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(waitCycles + 1));
        checkOutput({tag, " done"},     32'(Done), 32'd1);
        checkOutput({tag, " busy off"}, 32'(Busy), 32'd0);
        checkOutput({tag, " req off"},  32'(mem_req), 32'd0);
        checkOutput({tag, " fault"},    32'(Fault), 32'd0);
        checkOutput({tag, " rdata"},    ReadData, expRead);
        tick();
        checkOutput({tag, " done pulse"}, 32'(Done), 32'd0);
    endtask

    // Run an access that must be rejected without a bus request.
    task automatic faultAccess(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] expRead);
        applyStimulus(1'b1, we, f3, addr, 32'hA5A5_A5A5);
        tick();
        Start = 1'b0;
        checkOutput({tag, " done"},  32'(Done), 32'd1);
        checkOutput({tag, " fault"}, 32'(Fault), 32'd1);
        checkOutput({tag, " req"},   32'(mem_req), 32'd0);
        checkOutput({tag, " busy"},  32'(Busy), 32'd0);
        checkOutput({tag, " rdata"}, ReadData, expRead);
        tick();
        checkOutput({tag, " done pulse"}, 32'(Done), 32'd0);
        checkOutput({tag, " req after"},  32'(mem_req), 32'd0);
    endtask

    initial begin
        int busyCycles;
        logic doneSeen;

        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset busy",  32'(Busy), 32'd0);
        checkOutput("reset done",  32'(Done), 32'd0);
        checkOutput("reset rdata", ReadData, 32'h0);
        checkOutput("reset fault", 32'(Fault), 32'd0);
        checkOutput("reset req",   32'(mem_req), 32'd0);
        checkOutput("reset addr",  mem_addr, 32'h0);
        checkOutput("reset be",    32'(mem_be), 32'd0);

        // Loads of every width and extension.
        doAccess("LW",      1'b0, 3'b010, 32'h0000_0104, 32'h0, 3, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        doAccess("LB 203",  1'b0, 3'b000, 32'h0000_0203, 32'h0, 1, 32'h80FF_7F01, 4'b1000, 32'h0, 32'hFFFF_FF80);
        doAccess("LBU 203", 1'b0, 3'b100, 32'h0000_0203, 32'h0, 0, 32'h80FF_7F01, 4'b1000, 32'h0, 32'h0000_0080);
        doAccess("LHU 202", 1'b0, 3'b101, 32'h0000_0202, 32'h0, 2, 32'h80FF_7F01, 4'b1100, 32'h0, 32'h0000_80FF);
        doAccess("LH 200",  1'b0, 3'b001, 32'h0000_0200, 32'h0, 0, 32'h80FF_7F01, 4'b0011, 32'h0, 32'h0000_7F01);
        doAccess("LH 202",  1'b0, 3'b001, 32'h0000_0202, 32'h0, 1, 32'h80FF_7F01, 4'b1100, 32'h0, 32'hFFFF_80FF);
        doAccess("LB 201",  1'b0, 3'b000, 32'h0000_0201, 32'h0, 0, 32'h80FF_7F01, 4'b0010, 32'h0, 32'h0000_007F);

        // Stores leave ReadData at the last load value.
        doAccess("SH 102", 1'b1, 3'b001, 32'h0000_0102, 32'h1234_5678, 1, 32'hFFFF_FFFF, 4'b1100, 32'h5678_5678, 32'h0000_007F);
        doAccess("SB 101", 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 0, 32'hFFFF_FFFF, 4'b0010, 32'hABAB_ABAB, 32'h0000_007F);
        doAccess("SW 108", 1'b1, 3'b010, 32'h0000_0108, 32'hCAFE_F00D, 2, 32'hFFFF_FFFF, 4'b1111, 32'hCAFE_F00D, 32'h0000_007F);

        // Rejected accesses.
        faultAccess("LW 101",    1'b0, 3'b010, 32'h0000_0101, 32'h0000_007F);
        faultAccess("F3 011",    1'b0, 3'b011, 32'h0000_0100, 32'h0000_007F);
        faultAccess("LH 103",    1'b0, 3'b001, 32'h0000_0103, 32'h0000_007F);
        faultAccess("store 100", 1'b1, 3'b100, 32'h0000_0100, 32'h0000_007F);
        faultAccess("F3 110",    1'b0, 3'b110, 32'h0000_0100, 32'h0000_007F);

        // A clean access right after a fault reports Fault=00 again.
        doAccess("LW after fault", 1'b0, 3'b010, 32'h0000_0400, 32'h0, 0, 32'h0BAD_F00D, 4'b1111, 32'h0, 32'h0BAD_F00D);

        // Access with no ack.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        tick();
        Start      = 1'b0;
        busyCycles = 0;
        doneSeen   = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int i = 0; i < 40 && !doneSeen; i++) begin
            if (Done) doneSeen = 1'b1;
            else begin
                if (Busy) busyCycles++;
                tick();
            end
        end
        checkOutput("timeout done seen", 32'(doneSeen), 32'd1);
        checkOutput("timeout busy cycles", 32'(busyCycles), 32'd16);
        checkOutput("timeout fault", 32'(Fault), 32'd2);
        checkOutput("timeout req", 32'(mem_req), 32'd0);
        checkOutput("timeout rdata", ReadData, 32'h0BAD_F00D);
        tick();
        checkOutput("timeout done pulse", 32'(Done), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        tick();
        mem_ack   = 1'b0;
        checkOutput("stray ack done", 32'(Done), 32'd0);
        checkOutput("stray ack busy", 32'(Busy), 32'd0);
        checkOutput("stray ack rdata", ReadData, 32'h0BAD_F00D);
`else
        for (int i = 0; i < 40; i++) begin
            if (Done) doneSeen = 1'b1;
            if (Busy) busyCycles++;
            tick();
        end
        checkOutput("hold no done", 32'(doneSeen), 32'd0);
        checkOutput("hold busy cycles", 32'(busyCycles), 32'd40);
        checkOutput("hold req", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2222_3333;
        tick();
        mem_ack   = 1'b0;
        checkOutput("hold done", 32'(Done), 32'd1);
        checkOutput("hold fault", 32'(Fault), 32'd0);
        checkOutput("hold rdata", ReadData, 32'h2222_3333);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        tick();
        mem_ack   = 1'b0;
        checkOutput("stray ack done", 32'(Done), 32'd0);
        checkOutput("stray ack rdata", ReadData, 32'h2222_3333);
`endif

        // Reset while waiting clears everything; the next access is serviced normally.
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0500, 32'h7777_8888);
        tick();
        Start = 1'b0;
        checkOutput("pre-reset req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("wait reset req",   32'(mem_req), 32'd0);
        checkOutput("wait reset busy",  32'(Busy), 32'd0);
        checkOutput("wait reset we",    32'(mem_we), 32'd0);
        checkOutput("wait reset wdata", mem_wdata, 32'h0);
        checkOutput("wait reset rdata", ReadData, 32'h0);
        checkOutput("wait reset done",  32'(Done), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("post-reset stray ack", 32'(Done), 32'd0);
        doAccess("LW post reset", 1'b0, 3'b010, 32'h0000_0104, 32'h0, 0, 32'h1122_3344, 4'b1111, 32'h0, 32'h1122_3344);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
